// File: rtl/seqmon_pkg.sv
// ============================================================================
// Module   : seqmon_pkg
// Brief    : Shared types and constants for the sequence monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seqmon_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_SEQ_LEN = 8;

    // Expected counting order of sequence_counter; entries must be unique.
    localparam logic [DEF_WIDTH-1:0] SEQ_TABLE [DEF_SEQ_LEN] = '{
        4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8
    };

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_lookup.sv
// ============================================================================
// Module   : seq_lookup
// Brief    : Combinational table search, count_in -> {hit, idx}, lowest index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_lookup
    import seqmon_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int IDX_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic [WIDTH-1:0] count_in,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Descending scan so the lowest matching index is the final assignment.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = SEQ_LEN - 1; i >= 0; i--) begin
            if (count_in == WIDTH'(SEQ_TABLE[i])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sequence_monitor.sv
// ============================================================================
// Module   : sequence_monitor
// Brief    : Checks sequence_counter output against the expected order, locks,
//            flags mismatches, counts errors, pulses once per period.
//            Optional macro SEQMON_RESYNC_EN: re-acquire from the mismatching sample.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_monitor
    import seqmon_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SEQ_LEN  = DEF_SEQ_LEN,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             mismatch,
    output logic             period_done,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] exp_value
);

    localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam state_t ACQ_STATE = (LOCK_CNT == 1) ? LOCKED : TRACK;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [RUN_W-1:0]   run, run_nx;
    logic               mis_nx, pd_nx, err_inc;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic [WIDTH-1:0]   cur_exp;

    seq_lookup #(
        .WIDTH   (WIDTH),
        .SEQ_LEN (SEQ_LEN),
        .IDX_W   (IDX_W)
    ) u_lookup (
        .count_in (count_in),
        .hit      (hit),
        .idx      (hit_idx)
    );

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(SEQ_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cur_exp = WIDTH'(SEQ_TABLE[ptr]);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        run_nx   = run;
        mis_nx   = 1'b0;
        pd_nx    = 1'b0;
        err_inc  = 1'b0;
        if (in_valid) begin
            if (state == SEARCH) begin
                if (hit) begin
                    ptr_nx   = wrap_inc(hit_idx);
                    run_nx   = RUN_W'(1);
                    state_nx = ACQ_STATE;
                end else begin
                    mis_nx  = 1'b1;
                    err_inc = 1'b1;
                end
            end else if (count_in == cur_exp) begin
                ptr_nx = wrap_inc(ptr);
                if (state == TRACK) begin
                    run_nx = run + 1'b1;
                    if (run + 1'b1 >= RUN_W'(LOCK_CNT))
                        state_nx = LOCKED;
                end else begin
                    pd_nx = (ptr == IDX_W'(SEQ_LEN - 1));
                end
            end else begin
                mis_nx   = 1'b1;
                err_inc  = 1'b1;
                run_nx   = '0;
                ptr_nx   = '0;
                state_nx = SEARCH;
`ifdef SEQMON_RESYNC_EN
                // The bad sample may itself be a valid table point; restart from it.
                if (hit) begin
                    ptr_nx   = wrap_inc(hit_idx);
                    run_nx   = RUN_W'(1);
                    state_nx = ACQ_STATE;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            ptr         <= '0;
            run         <= '0;
            mismatch    <= 1'b0;
            period_done <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            run         <= run_nx;
            mismatch    <= mis_nx;
            period_done <= pd_nx;
            if (err_inc && (err_count != '1))
                err_count <= err_count + 1'b1;
        end
    end

    assign locked    = (state == LOCKED);
    assign exp_value = (state == SEARCH) ? '0 : cur_exp;

endmodule

`default_nettype wire

// File: tb/tb_sequence_monitor.sv
// ============================================================================
// Module   : tb_sequence_monitor
// Brief    : Directed self-checking bench for sequence_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] count_in;
    logic       locked, mismatch, period_done;
    logic [7:0] err_count;
    logic [3:0] exp_value;

    int tests = 0;
    int fails = 0;

    sequence_monitor dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .count_in    (count_in),
        .locked      (locked),
        .mismatch    (mismatch),
        .period_done (period_done),
        .err_count   (err_count),
        .exp_value   (exp_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic l, input logic m, input logic p,
                           input int e, input logic [3:0] x);
        chk({tag, ".locked"},      {31'd0, locked},      {31'd0, l});
        chk({tag, ".mismatch"},    {31'd0, mismatch},    {31'd0, m});
        chk({tag, ".period_done"}, {31'd0, period_done}, {31'd0, p});
        chk({tag, ".err_count"},   {24'd0, err_count},   e);
        chk({tag, ".exp_value"},   {28'd0, exp_value},   {28'd0, x});
    endtask

    // Apply one sample, let one rising edge take it, then check the registered outputs.
    task automatic smp(input string tag, input logic v, input logic [3:0] c,
                       input logic l, input logic m, input logic p,
                       input int e, input logic [3:0] x);
        in_valid = v;
        count_in = c;
        @(posedge clk);
        #1;
        chk_all(tag, l, m, p, e, x);
    endtask

    logic [3:0] seq [8];
    int         e;

    initial begin
        seq = '{4'd0, 4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};
        reset    = 1'b0;
        in_valid = 1'b0;
        count_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 0, 4'd0);
        reset = 1'b1;

        // Lock from 0, with an invalid cycle between the first two samples
        smp("t1_s0",  1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 0, 4'd1);
        smp("t5_inv", 1'b0, 4'd3,  1'b0, 1'b0, 1'b0, 0, 4'd1);
        smp("t1_s1",  1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 0, 4'd3);
        for (int i = 2; i < 8; i++)
            smp("t1_run", 1'b1, seq[i], 1'b1, 1'b0, (i == 7), 0, seq[(i + 1) % 8]);
        smp("t5_inv2", 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 0, 4'd0);
        smp("t5_v0",   1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 0, 4'd1);
        smp("t5_inv3", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 0, 4'd1);
        smp("t5_v1",   1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 0, 4'd3);

        // Mismatch while locked, then re-acquire
        smp("t3_3",    1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 0, 4'd7);
        smp("t3_7",    1'b1, 4'd7,  1'b1, 1'b0, 1'b0, 0, 4'd15);
        smp("t3_bad5", 1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 1, 4'd0);
        smp("t3_14",   1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 1, 4'd12);
        smp("t3_12",   1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 1, 4'd8);
        smp("t3_8",    1'b1, 4'd8,  1'b1, 1'b0, 1'b1, 1, 4'd0);
        for (int i = 0; i < 5; i++)
            smp("t3_rel", 1'b1, seq[i], 1'b1, 1'b0, 1'b0, 1, seq[i + 1]);
        // Repeated 15 where 14 is due
`ifdef SEQMON_RESYNC_EN
        smp("t3_rep15", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 2, 4'd14);
        smp("t3_r14",   1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 2, 4'd12);
`else
        smp("t3_rep15", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 2, 4'd0);
        smp("t3_r14",   1'b1, 4'd14, 1'b0, 1'b0, 1'b0, 2, 4'd12);
`endif
        smp("t3_r12",   1'b1, 4'd12, 1'b1, 1'b0, 1'b0, 2, 4'd8);
        smp("t3_r8",    1'b1, 4'd8,  1'b1, 1'b0, 1'b1, 2, 4'd0);

        // Asynchronous reset mid-period while locked
        smp("t6_0", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 2, 4'd1);
        smp("t6_1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 2, 4'd3);
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        chk_all("t6_async", 1'b0, 1'b0, 1'b0, 0, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Acquire mid-sequence at 7, then two full periods
        smp("t2_7",  1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 0, 4'd15);
        smp("t2_15", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 0, 4'd14);
        for (int k = 0; k < 11; k++)
            smp("t2_run", 1'b1, seq[(k + 5) % 8], 1'b1, 1'b0, (((k + 5) % 8) == 7), 0,
                seq[(k + 6) % 8]);

        // Saturation of the error counter
        for (int k = 0; k < 300; k++) begin
            e = (k + 1 > 255) ? 255 : k + 1;
            smp("t4_sat", 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, e, 4'd0);
        end
        smp("t4_idle", 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 255, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
